// File: rtl/core_trace_pkg.sv
// core_trace_pkg: shared widths, word-index and FSM encodings, and the record
// layout used by core_trace_capture and its record FIFO.
// Optional feature macro: CORE_TRACE_TIMESTAMP_EN adds a 32-bit timestamp
// field to each record and a sixth output word.
package core_trace_pkg;

  localparam int REC_W      = 32;
  localparam int DROP_CNT_W = 16;

`ifdef CORE_TRACE_TIMESTAMP_EN
  localparam int NUM_WORDS = 6;
`else
  localparam int NUM_WORDS = 5;
`endif

  typedef enum logic [2:0] {
    W_PC  = 3'd0,
    W_IR  = 3'd1,
    W_IN1 = 3'd2,
    W_IN2 = 3'd3,
    W_OUT = 3'd4,
    W_TS  = 3'd5
  } word_idx_e;

  localparam word_idx_e W_LAST = word_idx_e'(3'(NUM_WORDS - 1));

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  typedef struct packed {
`ifdef CORE_TRACE_TIMESTAMP_EN
    logic [REC_W-1:0] ts;
`endif
    logic [REC_W-1:0] alu_out;
    logic [REC_W-1:0] alu_in2;
    logic [REC_W-1:0] alu_in1;
    logic [REC_W-1:0] ir;
    logic [REC_W-1:0] pc;
  } trace_rec_t;

  // Select one output word of a record by word index.
  function automatic logic [REC_W-1:0] rec_word(input trace_rec_t r, input word_idx_e i);
    logic [REC_W-1:0] w;
    w = '0;
    case (i)
      W_PC:  w = r.pc;
      W_IR:  w = r.ir;
      W_IN1: w = r.alu_in1;
      W_IN2: w = r.alu_in2;
      W_OUT: w = r.alu_out;
`ifdef CORE_TRACE_TIMESTAMP_EN
      W_TS:  w = r.ts;
`endif
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: record-wide synchronous FIFO.
// Ports: clk, resetn (sync, active low); push/push_rec write a record,
// pop retires the head; head_rec is the current head (combinational read);
// full/empty/count reflect the registered occupancy.
// Push while full and pop while empty are ignored.
module trace_fifo
  import core_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  trace_rec_t             push_rec,
  input  logic                   pop,
  output trace_rec_t             head_rec,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;
  trace_rec_t    mem_q [DEPTH];

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_rec = mem_q[rd_ptr_q];
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_rec;
  end

endmodule

// File: rtl/core_trace_capture.sv
// core_trace_capture: captures one record per retiring instruction into a
// FIFO and serializes it as 32-bit words over a valid/ready stream.
// Ports: clk, resetn (sync, active low); trace_valid + trace_pc/ir/alu_in1/
// alu_in2/alu_out from the core (no back-pressure); out_valid/out_ready/
// out_data/out_last stream; drop_count counts records lost to overflow
// (saturating).
// Optional feature macro: CORE_TRACE_TIMESTAMP_EN appends a free-running
// cycle-count word to each record.
module core_trace_capture
  import core_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        trace_valid,
  input  logic [31:0] trace_pc,
  input  logic [31:0] trace_ir,
  input  logic [31:0] trace_alu_in1,
  input  logic [31:0] trace_alu_in2,
  input  logic [31:0] trace_alu_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [15:0] drop_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e                  state_q, state_d;
  word_idx_e               idx_q, idx_d;
  logic [DROP_CNT_W-1:0]   drop_q, drop_d;
  logic                    fifo_full, fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic                    push, pop, xfer;
  trace_rec_t              push_rec, head_rec;

`ifdef CORE_TRACE_TIMESTAMP_EN
  logic [REC_W-1:0] ts_q, ts_d;
  assign ts_d = ts_q + 32'd1;
`endif

  // Fullness comes from the registered count, so a final-word pop in the
  // same cycle never frees a slot for this cycle's capture.
  assign push       = trace_valid & ~fifo_full;
  assign drop_count = drop_q;

  always_comb begin
    push_rec         = '0;
    push_rec.pc      = trace_pc;
    push_rec.ir      = trace_ir;
    push_rec.alu_in1 = trace_alu_in1;
    push_rec.alu_in2 = trace_alu_in2;
    push_rec.alu_out = trace_alu_out;
`ifdef CORE_TRACE_TIMESTAMP_EN
    push_rec.ts      = ts_q;
`endif
  end

  always_comb begin
    drop_d = drop_q;
    if (trace_valid && fifo_full && (drop_q != '1)) drop_d = drop_q + DROP_CNT_W'(1);
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (push),
    .push_rec (push_rec),
    .pop      (pop),
    .head_rec (head_rec),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Serializer. Leaving S_IDLE on the push itself (not on the registered
  // non-empty flag) gives a first word in the cycle right after capture.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pop       = 1'b0;
    out_valid = (state_q == S_SEND);
    out_last  = out_valid && (idx_q == W_LAST);
    xfer      = out_valid && out_ready;
    out_data  = out_valid ? rec_word(head_rec, idx_q) : '0;
    if (state_q == S_IDLE) begin
      idx_d = W_PC;
      if (push || !fifo_empty) state_d = S_SEND;
    end else if (xfer) begin
      if (idx_q == W_LAST) begin
        pop   = 1'b1;
        idx_d = W_PC;
        // Empty after this pop unless a capture lands in the same cycle.
        if ((fifo_count == CW'(1)) && !push) state_d = S_IDLE;
      end else begin
        idx_d = word_idx_e'(idx_q + 3'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      idx_q   <= W_PC;
      drop_q  <= '0;
`ifdef CORE_TRACE_TIMESTAMP_EN
      ts_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
`ifdef CORE_TRACE_TIMESTAMP_EN
      ts_q    <= ts_d;
`endif
    end
  end

endmodule

// File: tb/tb_core_trace_capture.sv
// Bench for core_trace_capture: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_core_trace_capture;
  import core_trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int NW    = NUM_WORDS;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        trace_valid = 1'b0;
  logic [31:0] trace_pc = '0, trace_ir = '0, trace_alu_in1 = '0, trace_alu_in2 = '0, trace_alu_out = '0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_last;
  logic [31:0] out_data;
  logic [15:0] drop_count;

  int checks = 0;
  int failures = 0;

  // Reference model: records as word lists, words already sent of the head.
  typedef logic [NW-1:0][31:0] mrec_t;
  mrec_t mq[$];
  int    sent = 0;
  int    mdrops = 0;
  int    tsc = 0;
  bit    mdl_chk = 1'b0;

  typedef struct {
    bit          rst;
    bit          tv;
    logic [31:0] pc, ir, a, b, o;
    bit          rdy;
    bit          ev;
    logic [31:0] ed;
    bit          el;
    logic [15:0] edrop;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  core_trace_capture #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .trace_valid   (trace_valid),
    .trace_pc      (trace_pc),
    .trace_ir      (trace_ir),
    .trace_alu_in1 (trace_alu_in1),
    .trace_alu_in2 (trace_alu_in2),
    .trace_alu_out (trace_alu_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .drop_count    (drop_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit          ev, el;
    logic [31:0] ed;
    ev = (mq.size() > 0);
    ed = ev ? mq[0][sent] : 32'd0;
    el = ev && (sent == NW - 1);
    chk("mdl_valid", 32'(out_valid), 32'(ev));
    chk("mdl_data", out_data, ed);
    chk("mdl_last", 32'(out_last), 32'(el));
    chk("mdl_drops", 32'(drop_count), 32'(mdrops));
  endtask

  task automatic model_update();
    mrec_t r;
    int    sz;
    if (!resetn) begin
      mq.delete();
      sent = 0; mdrops = 0; tsc = 0;
      return;
    end
    sz = mq.size();
    if (sz > 0 && out_ready) begin
      if (sent == NW - 1) begin
        void'(mq.pop_front());
        sent = 0;
      end else sent++;
    end
    if (trace_valid) begin
      r = '0;
      r[0] = trace_pc; r[1] = trace_ir; r[2] = trace_alu_in1;
      r[3] = trace_alu_in2; r[4] = trace_alu_out;
`ifdef CORE_TRACE_TIMESTAMP_EN
      r[5] = 32'(tsc);
`endif
      if (sz < DEPTH) mq.push_back(r);
      else if (mdrops < 65535) mdrops++;
    end
    tsc++;
  endtask

  task automatic tick_chk();
    @(negedge clk);
    if (mdl_chk) model_check();
  endtask

  task automatic tick_edge();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    tick_chk();
    tick_edge();
  endtask

  task automatic set_in(input bit tv, input logic [31:0] pc, ir, a, b, o, input bit rdy);
    trace_valid = tv; trace_pc = pc; trace_ir = ir;
    trace_alu_in1 = a; trace_alu_in2 = b; trace_alu_out = o; out_ready = rdy;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    set_in(1'b0, 0, 0, 0, 0, 0, 1'b0);
    tick(); tick();
    resetn = 1'b1;
    mdl_chk = 1'b1;
  endtask

  task automatic add_vec(input bit rst, tv, input logic [31:0] pc, ir, a, b, o,
                         input bit rdy, ev, input logic [31:0] ed, input bit el);
    vec_t v;
    v.rst = rst; v.tv = tv; v.pc = pc; v.ir = ir; v.a = a; v.b = b; v.o = o;
    v.rdy = rdy; v.ev = ev; v.ed = ed; v.el = el; v.edrop = 16'd0;
    tbl.push_back(v);
  endtask

  // Timestamp build: every table push lands on the first edge after a
  // reset, so its stamp is 0.
  task automatic add_ts_row();
`ifdef CORE_TRACE_TIMESTAMP_EN
    add_vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'd0, 1);
`endif
  endtask

  initial begin
    int n;
    int nts;
    logic [31:0] exp_ts [2];

    do_reset();
    // Reset state
    tick_chk();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    tick_edge();
    do_reset();

    // Single record, out_ready held high
    add_vec(0, 1, 32'h4, 32'h00500093, 0, 5, 5, 1, 0, 32'h0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h4, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h00500093, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h5, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h5, NW == 5);
    add_ts_row();
    add_vec(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0);
    // Reset, then back-pressure 1,0,0,1 inside a record
    add_vec(1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0);
    add_vec(0, 1, 32'h100, 32'h200, 32'h300, 32'h400, 32'h500, 1, 0, 32'h0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h100, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h200, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h300, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h400, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h500, NW == 5);
    add_ts_row();
    add_vec(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      resetn = !tbl[i].rst;
      set_in(tbl[i].tv, tbl[i].pc, tbl[i].ir, tbl[i].a, tbl[i].b, tbl[i].o, tbl[i].rdy);
      tick_chk();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_data", i), out_data, tbl[i].ed);
      chk($sformatf("vec%0d_last", i), 32'(out_last), 32'(tbl[i].el));
      chk($sformatf("vec%0d_drops", i), 32'(drop_count), 32'(tbl[i].edrop));
      tick_edge();
    end
    resetn = 1'b1;

    // Overflow: 10 captures into a stalled FIFO of 8
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(1, 32'(i + 1), 32'h1000 + 32'(i), 32'(i), 32'(2 * i), 32'(3 * i), 0);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick_chk();
    chk("ovf_drops", 32'(drop_count), 32'd2);
    tick_edge();
    out_ready = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      for (int w = 0; w < NW; w++) begin
        tick_chk();
        chk("ovf_valid", 32'(out_valid), 32'd1);
        if (w == 0) chk("ovf_pc_order", out_data, 32'(k));
        tick_edge();
      end
    end
    tick_chk();
    chk("ovf_drained", 32'(out_valid), 32'd0);
    tick_edge();

    // Full FIFO, final-word handshake and a capture in the same cycle
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1, 32'h50 + 32'(i), 32'h60 + 32'(i), 1, 2, 3, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 1);
    for (int w = 0; w < NW - 1; w++) tick();
    set_in(1, 32'hDEAD, 32'hBEEF, 7, 8, 9, 1);
    tick_chk();
    chk("sim_last", 32'(out_last), 32'd1);
    tick_edge();
    set_in(0, 0, 0, 0, 0, 0, 1);
    n = 0;
    tick_chk();
    chk("sim_drops", 32'(drop_count), 32'd1);
    tick_edge();
    for (int c = 0; c < NW * 10; c++) begin
      tick_chk();
      if (out_valid && out_last) n++;
      tick_edge();
    end
    chk("sim_records_left", 32'(n), 32'd7);

    // Reset mid-record, with drops pending and a capture during reset
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      set_in(1, 32'h70 + 32'(i), 0, 0, 0, 0, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 1);
    tick(); tick(); tick();
    resetn = 1'b0;
    set_in(1, 32'h99, 32'h99, 0, 0, 0, 1);
    tick();
    resetn = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 1);
    tick_chk();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_drops", 32'(drop_count), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    tick_edge();
    for (int c = 0; c < 10; c++) begin
      tick_chk();
      chk("mid_rst_stale", 32'(out_valid), 32'd0);
      tick_edge();
    end

`ifdef CORE_TRACE_TIMESTAMP_EN
    // Captures at cycles 3 and 7 after reset release
    do_reset();
    exp_ts[0] = 32'd3; exp_ts[1] = 32'd7;
    nts = 0;
    for (int c = 0; c < 24; c++) begin
      set_in((c == 3) || (c == 7), 32'(c), 0, 0, 0, 0, 1);
      tick_chk();
      if (out_valid && out_last) begin
        if (nts < 2) chk("ts_word", out_data, exp_ts[nts]);
        nts++;
      end
      tick_edge();
    end
    chk("ts_records", 32'(nts), 32'd2);
`else
    nts = 0;
    exp_ts[0] = 32'd0; exp_ts[1] = 32'd0;
`endif

    // Randomized traffic with phases of light and heavy back-pressure
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      resetn = ($urandom_range(0, 399) != 0);
      set_in($urandom_range(0, 1) == 1, $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom_range(0, 9) < (((c / 400) % 2 == 0) ? 8 : 3));
      tick();
    end
    resetn = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < DEPTH * NW + 4; c++) tick();
    tick_chk();
    chk("final_drained", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_trace_capture.md
CORE_TRACE_CAPTURE -- requirements
Module: core_trace_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning record-FIFO capacity in records (power of two, 2..64).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port trace_valid  input  1  core retires one instruction this cycle; no back-pressure to the core.
REQ-005 SHALL have ports trace_pc, trace_ir, trace_alu_in1, trace_alu_in2, trace_alu_out  input  32 each  the core observation values for the retiring instruction.
REQ-006 SHALL have port out_valid  output  1  out_data holds a valid trace word.
REQ-007 SHALL have port out_ready  input  1  consumer accepts the word.
REQ-008 SHALL have port out_data  output  32  trace word.
REQ-009 SHALL have port out_last  output  1  marks the final word of a record.
REQ-010 SHALL have port drop_count  output  16  number of records lost to overflow.

Function
REQ-011 SHALL capture all five trace inputs as one record on each cycle with trace_valid=1 and FIFO not full.
REQ-012 SHALL evaluate fullness on the registered count at the start of the cycle; a pop in the same cycle never makes room for a push.
REQ-013 SHALL discard the record when trace_valid=1 and FIFO is full, and increment drop_count, saturating at 0xFFFF.
REQ-014 SHALL emit each record as consecutive words: PC, IR, AluIn1, AluIn2, AluOut, plus the timestamp word when configured (REQ-024).
REQ-015 SHALL transfer a word only on a cycle with out_valid=1 and out_ready=1.
REQ-016 SHALL hold out_data and out_last stable, and keep out_valid high, until that word transfers.
REQ-017 SHALL use a serializer FSM with two states:
- S_IDLE to S_SEND when the FIFO is non-empty.
- S_SEND: word index 0..N-1, advancing on each handshake.
- After the handshake on word N-1: pop the record, then go to S_IDLE if the FIFO becomes empty, else stay in S_SEND with index 0.
REQ-018 SHALL assert out_last only while the word index equals N-1 in S_SEND.
REQ-019 SHALL drive out_data from the FIFO head combinationally, giving first-word latency of one cycle after the push edge.
REQ-020 SHALL support simultaneous push and final-word pop, with count unchanged and pointers wrapping modulo DEPTH.
REQ-021 SHALL accept back-to-back pushes every cycle up to DEPTH records without loss.

Reset
REQ-022 SHALL, with resetn=0 at a clock edge, clear all of the following (including reset asserted mid-record, which discards the partial record):
- pointers and count to 0
- FSM to S_IDLE, word index to 0
- out_valid=0, out_last=0, out_data=0
- drop_count=0
- timestamp counter to 0
REQ-023 SHALL ignore trace_valid during the cycle reset is asserted.

Configuration
REQ-024 SHALL, with macro CORE_TRACE_TIMESTAMP_EN defined, implement a free-running 32-bit cycle counter (wraps 0xFFFFFFFF to 0), store its value at capture in each record, and emit it as a sixth word; N=6.
REQ-025 SHALL, without CORE_TRACE_TIMESTAMP_EN, omit the counter and its storage; N=5.

Structure
REQ-026 SHALL place in a shared package core_trace_pkg: the record field widths (32), the word-index encodings, the FSM state encodings, and the DROP_CNT_W=16 constant.
REQ-027 SHALL instantiate one sub-module, trace_fifo: a record-wide synchronous FIFO with push/pop/full/empty/count.

Verification
REQ-028 Single record: trace_valid pulse with PC=0x00000004, IR=0x00500093, AluIn1=0, AluIn2=5, AluOut=5, out_ready=1 -> words 0x4, 0x00500093, 0, 5, 5 on consecutive cycles, out_last on the 5th only.
REQ-029 Back-pressure: out_ready toggles 1,0,0,1 during a record -> no word duplicated or skipped, and out_data stable while out_ready=0.
REQ-030 Overflow: out_ready=0 and 10 consecutive trace_valid with DEPTH=8 -> 8 records stored, drop_count=2; draining then yields records 1..8 in order.
REQ-031 Simultaneous: FIFO full and final-word handshake coincide with trace_valid -> new record dropped, drop_count +1, count becomes 7.
REQ-032 Reset mid-record: resetn=0 after word 2 is transferred -> next cycle out_valid=0, drop_count=0, and no stale words after reset release.
REQ-033 Timestamp (macro defined): captures at cycles 3 and 7 after reset release -> sixth words 3 and 7, out_last on word 6.
